// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode and load-use hazard detection
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic            flush,
    input  logic            hold,
    output logic            stall,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_branch_ne,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic       dec_legal;
    logic [3:0] dec_alu;
    logic       dec_use_imm;
    logic       dec_reg_write;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_use_rs2;
    logic       hazard;

    always_comb begin
        dec_legal     = 1'b0;
        dec_alu       = ALU_ADD;
        dec_use_imm   = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_use_rs2   = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec_legal     = 1'b1;
                dec_reg_write = 1'b1;
                dec_use_rs2   = 1'b1;
                case (id_funct3)
                    3'b000: dec_alu = id_funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111: dec_alu = ALU_AND;
                    3'b110: dec_alu = ALU_OR;
                    3'b001: dec_alu = ALU_SLL;
                    3'b101: dec_alu = id_funct7_5 ? ALU_SRA : ALU_SRL;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec_legal     = 1'b1;
                dec_reg_write = 1'b1;
                dec_use_imm   = 1'b1;
                case (id_funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_legal     = (id_funct3 == 3'b010);
                dec_use_imm   = 1'b1;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_STORE: begin
                dec_legal     = (id_funct3 == 3'b010);
                dec_use_imm   = 1'b1;
                dec_mem_write = 1'b1;
                dec_use_rs2   = 1'b1;
            end
            OP_BR: begin
                dec_legal   = (id_funct3[2:1] == 2'b00);
                dec_alu     = ALU_SUB;
                dec_branch  = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Unsupported encodings use no sources, so they never trigger a stall.
    assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && dec_legal &&
                    ((id_rs1 == ex_rd) || (dec_use_rs2 && (id_rs2 == ex_rd)));

    assign stall = (hazard || hold) && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!hold && (hazard || !id_valid || !dec_legal))) begin
            ex_valid      <= 1'b0;
            ex_alu_ctrl   <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_branch_ne  <= 1'b0;
            ex_pc         <= '0;
            // Only a real, unstalled ID instruction with a bad encoding marks the slot.
            ex_illegal    <= rst_n && !flush && !hazard && id_valid && !dec_legal;
        end else if (!hold) begin
            ex_valid      <= 1'b1;
            ex_alu_ctrl   <= dec_alu;
            ex_a          <= id_rs1_data;
            ex_b          <= dec_use_imm ? id_imm : id_rs2_data;
            ex_store_data <= id_rs2_data;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_reg_write  <= dec_reg_write && (id_rd != '0);
            ex_mem_read   <= dec_mem_read;
            ex_mem_write  <= dec_mem_write;
            ex_branch     <= dec_branch;
            ex_branch_ne  <= dec_branch && id_funct3[0];
            ex_pc         <= id_pc;
            ex_illegal    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - table-driven and sequence checks for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        flush, hold;
    logic        stall, ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_pc(id_pc), .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        e_valid;
        logic [3:0]  e_alu;
        logic [31:0] e_b;
        logic        e_rw, e_mr, e_mw, e_br, e_bne, e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm);
        id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_funct7_5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        id_rs1_data = 32'd7; id_rs2_data = 32'd5; id_pc = 32'h100;
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);

        vecs.push_back('{"add",   7'b0110011, 3'b000, 1'b0, 5'd3, 32'h0,        1, 4'b0010, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"sub",   7'b0110011, 3'b000, 1'b1, 5'd3, 32'h0,        1, 4'b0110, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"addi",  7'b0010011, 3'b000, 1'b0, 5'd4, 32'hFFFFFFFD, 1, 4'b0010, 32'hFFFFFFFD, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{"ori",   7'b0010011, 3'b110, 1'b0, 5'd4, 32'h10,       1, 4'b0001, 32'h10,       1, 0, 0, 0, 0, 0});
        vecs.push_back('{"andi",  7'b0010011, 3'b111, 1'b0, 5'd4, 32'h0F,       1, 4'b0000, 32'h0F,       1, 0, 0, 0, 0, 0});
        vecs.push_back('{"sra",   7'b0110011, 3'b101, 1'b1, 5'd7, 32'h0,        1, 4'b0101, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"srl",   7'b0110011, 3'b101, 1'b0, 5'd7, 32'h0,        1, 4'b0100, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"sll",   7'b0110011, 3'b001, 1'b0, 5'd7, 32'h0,        1, 4'b0011, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"and",   7'b0110011, 3'b111, 1'b0, 5'd7, 32'h0,        1, 4'b0000, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"or",    7'b0110011, 3'b110, 1'b0, 5'd7, 32'h0,        1, 4'b0001, 32'd5,        1, 0, 0, 0, 0, 0});
        vecs.push_back('{"lw",    7'b0000011, 3'b010, 1'b0, 5'd5, 32'h8,        1, 4'b0010, 32'h8,        1, 1, 0, 0, 0, 0});
        vecs.push_back('{"sw",    7'b0100011, 3'b010, 1'b0, 5'd0, 32'h4,        1, 4'b0010, 32'h4,        0, 0, 1, 0, 0, 0});
        vecs.push_back('{"beq",   7'b1100011, 3'b000, 1'b0, 5'd0, 32'h20,       1, 4'b0110, 32'd5,        0, 0, 0, 1, 0, 0});
        vecs.push_back('{"bne",   7'b1100011, 3'b001, 1'b0, 5'd0, 32'h20,       1, 4'b0110, 32'd5,        0, 0, 0, 1, 1, 0});
        vecs.push_back('{"lui",   7'b0110111, 3'b000, 1'b0, 5'd3, 32'h1000,     0, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 1});
        vecs.push_back('{"add0",  7'b0110011, 3'b000, 1'b0, 5'd0, 32'h0,        1, 4'b0010, 32'd5,        0, 0, 0, 0, 0, 0});
        vecs.push_back('{"lb",    7'b0000011, 3'b000, 1'b0, 5'd5, 32'h8,        0, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 1});
        vecs.push_back('{"slli",  7'b0010011, 3'b001, 1'b0, 5'd4, 32'h1,        0, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 1});

        // Reset with a valid instruction presented
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_alu", ex_alu_ctrl, 0);
        chk("rst_a", ex_a, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", ex_valid, 1);
        chk("post_rst_alu", ex_alu_ctrl, 4'b0010);
        chk("post_rst_pc", ex_pc, 32'h100);
        idle();

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 5'd1, 5'd2, vecs[i].rd, vecs[i].imm);
            tick();
            chk({vecs[i].name, "_valid"}, ex_valid, vecs[i].e_valid);
            chk({vecs[i].name, "_alu"}, ex_alu_ctrl, vecs[i].e_alu);
            chk({vecs[i].name, "_a"}, ex_a, vecs[i].e_valid ? 32'd7 : 32'd0);
            chk({vecs[i].name, "_b"}, ex_b, vecs[i].e_b);
            chk({vecs[i].name, "_ctl"},
                {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_illegal},
                {vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_br, vecs[i].e_bne, vecs[i].e_ill});
            if (vecs[i].e_mw) chk({vecs[i].name, "_store"}, ex_store_data, 32'd5);
            idle();
        end

        // Load-use: one stall cycle, one bubble, then the dependent ADD
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'h8);
        tick();
        drive(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 32'h0);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_drop", stall, 0);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        idle();

        // LW x0 never creates a hazard
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd0, 32'h8);
        tick();
        drive(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd6, 32'h0);
        #1 chk("lw0_stall", stall, 0);
        tick();
        chk("lw0_add_valid", ex_valid, 1);
        idle();

        // Hazard with flush: flush wins
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'h8);
        tick();
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd5, 5'd6, 32'h0);
        flush = 1'b1;
        #1 chk("hf_stall", stall, 0);
        tick();
        flush = 1'b0;
        chk("hf_valid", ex_valid, 0);
        chk("hf_mem_read", ex_mem_read, 0);
        idle();

        // Hold for three cycles freezes the EX slot
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick();
        drive(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd9, 32'h0);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_stall", stall, 1);
            tick();
            chk("hold_alu", ex_alu_ctrl, 4'b0010);
            chk("hold_rd", ex_rd, 3);
            chk("hold_valid", ex_valid, 1);
        end
        flush = 1'b1;
        tick();
        chk("hold_flush_valid", ex_valid, 0);
        hold = 1'b0; flush = 1'b0;

        // Held illegal slot keeps ex_illegal
        drive(7'b0110111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick();
        hold = 1'b1;
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0);
        tick();
        chk("hold_illegal", ex_illegal, 1);
        hold = 1'b0;
        idle();
        chk("illegal_clear", ex_illegal, 0);

        // Reset during a load-use stall
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'h8);
        tick();
        drive(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 32'h0);
        #1 chk("rs_stall", stall, 1);
        rst_n = 1'b0;
        tick();
        chk("rs_valid", ex_valid, 0);
        chk("rs_stall_after", stall, 0);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
